// File: rtl/fft_mem_pkg.sv
// Shared constants and types for the FFT engine's ping-pong SRAM responder.
package fft_mem_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Maps any address onto a bank row; a no-op while DEPTH == 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] addr);
    return ADDR_W'(int'(addr) % DEPTH);
  endfunction

endpackage

// File: rtl/fft_sram_bank.sv
// One SRAM bank: two registered engine read ports, two engine write ports
// (port 2 wins on a shared address) and a host read/write port, read-first.
module fft_sram_bank
  import fft_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic              host_en,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch; clearing DEPTH wide words on reset
  // would force it out of RAM and the contents are not architecturally defined.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates make every read in this cycle see the old
    // word (read-first) and let the later port-2 assignment win a tie.
    if (we) begin
      mem[wrap_addr(waddr1)] <= wdata1;
      mem[wrap_addr(waddr2)] <= wdata2;
    end
    if (host_en && host_we) begin
      mem[wrap_addr(host_addr)] <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata1     <= '0;
      rdata2     <= '0;
      host_rdata <= '0;
    end else begin
      rdata1 <= mem[wrap_addr(raddr1)];
      rdata2 <= mem[wrap_addr(raddr2)];
      // Host data is held between reads so the top can expose it indefinitely.
      if (host_en && !host_we) begin
        host_rdata <= mem[wrap_addr(host_addr)];
      end
    end
  end

endmodule

// File: rtl/fft_sram_responder.sv
// Memory-side responder for the FFT engine: ping-pong banks steered by the
// engine's read-register select, a host load/unload port and the run FSM.
module fft_sram_responder
  import fft_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] i_raddress1,
  input  logic [ADDR_W-1:0] i_raddress2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic [ADDR_W-1:0] i_waddress1,
  input  logic [ADDR_W-1:0] i_waddress2,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic [DATA_W-1:0] i_wdata2,
  input  logic              i_global_write_enable,
  input  logic              i_sram_read_register,
  input  logic              i_fft_done,
  output logic              o_working,
  input  logic              i_start,
  output logic              o_done,
  output logic              o_result_bank,
  input  logic              i_host_valid,
  output logic              o_host_ready,
  input  logic              i_host_we,
  input  logic              i_host_bank,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_rvalid,
  output logic [DATA_W-1:0] o_host_rdata
);

  state_t            state;
  state_t            state_next;
  bank_sel_t         read_bank;
  bank_sel_t         host_bank;
  bank_sel_t         rd_bank_q;
  bank_sel_t         host_bank_q;
  logic              eng_we;
  logic              host_hs;
  logic [DATA_W-1:0] a_rdata1;
  logic [DATA_W-1:0] a_rdata2;
  logic [DATA_W-1:0] b_rdata1;
  logic [DATA_W-1:0] b_rdata2;
  logic [DATA_W-1:0] a_host_rdata;
  logic [DATA_W-1:0] b_host_rdata;

  assign read_bank = bank_sel_t'(i_sram_read_register);
  assign host_bank = bank_sel_t'(i_host_bank);
  assign eng_we    = i_global_write_enable && (state == RUN);
  assign host_hs   = i_host_valid && o_host_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next   = state;
    o_working    = 1'b0;
    o_done       = 1'b0;
    o_host_ready = 1'b0;
    unique case (state)
      IDLE: begin
        o_host_ready = 1'b1;
        if (i_start) state_next = RUN;
      end
      RUN: begin
        o_working = 1'b1;
        if (i_fft_done) state_next = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Engine writes land in whichever bank is not being read.
  fft_sram_bank u_bank_a (
    .clk        (clk),
    .rstn       (rstn),
    .raddr1     (i_raddress1),
    .raddr2     (i_raddress2),
    .rdata1     (a_rdata1),
    .rdata2     (a_rdata2),
    .we         (eng_we && (read_bank == BANK_B)),
    .waddr1     (i_waddress1),
    .waddr2     (i_waddress2),
    .wdata1     (i_wdata1),
    .wdata2     (i_wdata2),
    .host_en    (host_hs && (host_bank == BANK_A)),
    .host_we    (i_host_we),
    .host_addr  (i_host_addr),
    .host_wdata (i_host_wdata),
    .host_rdata (a_host_rdata)
  );

  fft_sram_bank u_bank_b (
    .clk        (clk),
    .rstn       (rstn),
    .raddr1     (i_raddress1),
    .raddr2     (i_raddress2),
    .rdata1     (b_rdata1),
    .rdata2     (b_rdata2),
    .we         (eng_we && (read_bank == BANK_A)),
    .waddr1     (i_waddress1),
    .waddr2     (i_waddress2),
    .wdata1     (i_wdata1),
    .wdata2     (i_wdata2),
    .host_en    (host_hs && (host_bank == BANK_B)),
    .host_we    (i_host_we),
    .host_addr  (i_host_addr),
    .host_wdata (i_host_wdata),
    .host_rdata (b_host_rdata)
  );

  // The select is captured with the address so the output mux matches the
  // bank that actually served the registered read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_bank_q     <= BANK_A;
      host_bank_q   <= BANK_A;
      o_host_rvalid <= 1'b0;
      o_result_bank <= 1'b0;
    end else begin
      rd_bank_q     <= read_bank;
      o_host_rvalid <= host_hs && !i_host_we;
      if (host_hs && !i_host_we) begin
        host_bank_q <= host_bank;
      end
      if (eng_we) begin
        o_result_bank <= ~i_sram_read_register;
      end
    end
  end

  assign o_rdata1     = (rd_bank_q == BANK_B) ? b_rdata1 : a_rdata1;
  assign o_rdata2     = (rd_bank_q == BANK_B) ? b_rdata2 : a_rdata2;
  assign o_host_rdata = (host_bank_q == BANK_B) ? b_host_rdata : a_host_rdata;

endmodule

// File: tb/tb_fft_sram_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a behavioural two-bank memory model.
module tb_fft_sram_responder;
  import fft_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [ADDR_W-1:0] i_raddress1, i_raddress2, i_waddress1, i_waddress2, i_host_addr;
  logic [DATA_W-1:0] i_wdata1, i_wdata2, i_host_wdata;
  logic [DATA_W-1:0] o_rdata1, o_rdata2, o_host_rdata;
  logic i_global_write_enable, i_sram_read_register, i_fft_done, i_start;
  logic i_host_valid, i_host_we, i_host_bank;
  logic o_working, o_done, o_result_bank, o_host_ready, o_host_rvalid;

  always #5 clk = ~clk;

  fft_sram_responder dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .i_raddress1           (i_raddress1),
    .i_raddress2           (i_raddress2),
    .o_rdata1              (o_rdata1),
    .o_rdata2              (o_rdata2),
    .i_waddress1           (i_waddress1),
    .i_waddress2           (i_waddress2),
    .i_wdata1              (i_wdata1),
    .i_wdata2              (i_wdata2),
    .i_global_write_enable (i_global_write_enable),
    .i_sram_read_register  (i_sram_read_register),
    .i_fft_done            (i_fft_done),
    .o_working             (o_working),
    .i_start               (i_start),
    .o_done                (o_done),
    .o_result_bank         (o_result_bank),
    .i_host_valid          (i_host_valid),
    .o_host_ready          (o_host_ready),
    .i_host_we             (i_host_we),
    .i_host_bank           (i_host_bank),
    .i_host_addr           (i_host_addr),
    .i_host_wdata          (i_host_wdata),
    .o_host_rvalid         (o_host_rvalid),
    .o_host_rdata          (o_host_rdata)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [DATA_W-1:0] act,
                            input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two word arrays with per-word "known" flags, plus
  // the run/done phase of the engine handshake.
  logic [DATA_W-1:0] m_mem   [2][DEPTH];
  bit                m_known [2][DEPTH];
  bit                m_running, m_done_pulse, m_result_bank, m_rvalid;
  bit                m_hknown, m_rd1_known, m_rd2_known;
  logic [DATA_W-1:0] m_hrdata, m_rd1, m_rd2;

  task automatic model_reset();
    m_running     = 1'b0;
    m_done_pulse  = 1'b0;
    m_result_bank = 1'b0;
    m_rvalid      = 1'b0;
    m_hrdata      = '0;
    m_hknown      = 1'b1;
    m_rd1         = '0;
    m_rd2         = '0;
    m_rd1_known   = 1'b1;
    m_rd2_known   = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) m_known[b][a] = 1'b0;
  endtask

  always @(posedge clk) begin : model_step
    bit rb;
    bit idle;
    if (rstn) begin
      rb   = i_sram_read_register;
      idle = !m_running && !m_done_pulse;
      // Engine reads see the memory as it was before this edge's writes.
      m_rd1       = m_mem[rb][i_raddress1];
      m_rd1_known = m_known[rb][i_raddress1];
      m_rd2       = m_mem[rb][i_raddress2];
      m_rd2_known = m_known[rb][i_raddress2];
      m_rvalid    = 1'b0;
      if (i_host_valid && idle) begin
        if (i_host_we) begin
          m_mem[i_host_bank][i_host_addr]   = i_host_wdata;
          m_known[i_host_bank][i_host_addr] = 1'b1;
        end else begin
          m_rvalid = 1'b1;
          m_hrdata = m_mem[i_host_bank][i_host_addr];
          m_hknown = m_known[i_host_bank][i_host_addr];
        end
      end
      if (m_running && i_global_write_enable) begin
        m_mem[!rb][i_waddress1]   = i_wdata1;
        m_known[!rb][i_waddress1] = 1'b1;
        m_mem[!rb][i_waddress2]   = i_wdata2;
        m_known[!rb][i_waddress2] = 1'b1;
        m_result_bank = !rb;
      end
      if (m_done_pulse) begin
        m_done_pulse = 1'b0;
      end else if (m_running) begin
        if (i_fft_done) begin
          m_running    = 1'b0;
          m_done_pulse = 1'b1;
        end
      end else if (i_start) begin
        m_running = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && cmp_en) begin
      check1("working", o_working, m_running);
      check1("done", o_done, m_done_pulse);
      check1("host_ready", o_host_ready, !m_running && !m_done_pulse);
      check1("result_bank", o_result_bank, m_result_bank);
      check1("host_rvalid", o_host_rvalid, m_rvalid);
      if (m_hknown) check_word("host_rdata", o_host_rdata, m_hrdata);
      if (m_rd1_known) check_word("rdata1", o_rdata1, m_rd1);
      if (m_rd2_known) check_word("rdata2", o_rdata2, m_rd2);
    end
  end

  task automatic idle_inputs();
    i_raddress1 = '0; i_raddress2 = '0; i_waddress1 = '0; i_waddress2 = '0;
    i_wdata1 = '0; i_wdata2 = '0; i_global_write_enable = 1'b0;
    i_sram_read_register = 1'b0; i_fft_done = 1'b0; i_start = 1'b0;
    i_host_valid = 1'b0; i_host_we = 1'b0; i_host_bank = 1'b0;
    i_host_addr = '0; i_host_wdata = '0;
  endtask

  task automatic host_write(input logic b, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    i_host_valid = 1'b1; i_host_we = 1'b1; i_host_bank = b;
    i_host_addr = a; i_host_wdata = d;
    @(negedge clk);
    i_host_valid = 1'b0; i_host_we = 1'b0;
  endtask

  task automatic host_read(input logic b, input logic [ADDR_W-1:0] a);
    i_host_valid = 1'b1; i_host_we = 1'b0; i_host_bank = b; i_host_addr = a;
    @(negedge clk);
    i_host_valid = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    // Mostly a small window so reads hit previously written words.
    if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, DEPTH - 1));
    return ADDR_W'($urandom_range(0, 15));
  endfunction

  localparam logic [DATA_W-1:0] W_A5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] W_3C = {16{8'h3C}};
  localparam logic [DATA_W-1:0] W10  = 128'h0010_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [DATA_W-1:0] W20  = 128'h0020_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
  localparam logic [DATA_W-1:0] W5   = 128'h0005_0000_0000_0000_0000_0000_0000_0A05;
  localparam logic [DATA_W-1:0] W6   = 128'h0006_0000_0000_0000_0000_0000_0000_0A06;
  localparam logic [DATA_W-1:0] X    = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0005;
  localparam logic [DATA_W-1:0] Y    = 128'hCAFE_F00D_0000_0000_0000_0000_0000_0006;
  localparam logic [DATA_W-1:0] P    = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;
  localparam logic [DATA_W-1:0] Q    = 128'h0FED_CBA9_8765_4321_0FED_CBA9_8765_4321;

  initial begin
    idle_inputs();
    model_reset();
    #1;
    check1("reset_working", o_working, 1'b0);
    check1("reset_done", o_done, 1'b0);
    check1("reset_result_bank", o_result_bank, 1'b0);
    check1("reset_rvalid", o_host_rvalid, 1'b0);
    check_word("reset_host_rdata", o_host_rdata, '0);
    check_word("reset_rdata1", o_rdata1, '0);
    check_word("reset_rdata2", o_rdata2, '0);
    @(negedge clk);
    rstn   = 1'b1;
    cmp_en = 1'b1;

    // Host write/read round trip on both banks.
    host_write(1'b0, 8'd3, W_A5);
    host_write(1'b1, 8'd3, W_3C);
    host_read(1'b0, 8'd3);
    check1("tp1_rvalid", o_host_rvalid, 1'b1);
    check_word("tp1_rdata_a", o_host_rdata, W_A5);
    host_read(1'b1, 8'd3);
    check_word("tp1_rdata_b", o_host_rdata, W_3C);
    @(negedge clk);
    check1("tp1_rvalid_drop", o_host_rvalid, 1'b0);
    check_word("tp1_rdata_hold", o_host_rdata, W_3C);

    // Engine reads from bank A, one cycle latency.
    host_write(1'b0, 8'd10, W10);
    host_write(1'b0, 8'd20, W20);
    host_write(1'b0, 8'd5, W5);
    host_write(1'b0, 8'd6, W6);
    i_sram_read_register = 1'b0;
    i_raddress1 = 8'd10;
    i_raddress2 = 8'd20;
    @(negedge clk);
    check_word("tp2_rdata1", o_rdata1, W10);
    check_word("tp2_rdata2", o_rdata2, W20);

    // Start with a simultaneous host read; host stalls while running.
    i_start = 1'b1;
    i_host_valid = 1'b1; i_host_we = 1'b0; i_host_bank = 1'b0; i_host_addr = 8'd10;
    @(negedge clk);
    i_start = 1'b0;
    check1("tp3_working", o_working, 1'b1);
    check1("tp3_ready", o_host_ready, 1'b0);
    check_word("tp3_same_cycle_read", o_host_rdata, W10);
    repeat (2) @(negedge clk);
    check1("tp3_stalled", o_host_rvalid, 1'b0);
    i_host_valid = 1'b0;

    // Engine writes to bank B, then a port collision at address 7.
    i_global_write_enable = 1'b1;
    i_waddress1 = 8'd5; i_wdata1 = X;
    i_waddress2 = 8'd6; i_wdata2 = Y;
    @(negedge clk);
    i_waddress1 = 8'd7; i_wdata1 = P;
    i_waddress2 = 8'd7; i_wdata2 = Q;
    @(negedge clk);
    i_global_write_enable = 1'b0;
    check1("tp4_result_bank", o_result_bank, 1'b1);

    // Completion handshake.
    i_fft_done = 1'b1;
    @(negedge clk);
    i_fft_done = 1'b0;
    check1("tp6_done", o_done, 1'b1);
    check1("tp6_working", o_working, 1'b0);
    @(negedge clk);
    check1("tp6_done_once", o_done, 1'b0);
    check1("tp6_ready", o_host_ready, 1'b1);

    host_read(1'b1, 8'd5); check_word("tp4_b5", o_host_rdata, X);
    host_read(1'b1, 8'd6); check_word("tp4_b6", o_host_rdata, Y);
    host_read(1'b1, 8'd7); check_word("tp5_port2_wins", o_host_rdata, Q);
    host_read(1'b0, 8'd5); check_word("tp4_a5_kept", o_host_rdata, W5);
    host_read(1'b0, 8'd6); check_word("tp4_a6_kept", o_host_rdata, W6);

    // Engine writes in IDLE are dropped; done in IDLE is ignored.
    i_global_write_enable = 1'b1;
    i_wdata1 = rand_word(); i_wdata2 = rand_word();
    i_fft_done = 1'b1;
    @(negedge clk);
    i_global_write_enable = 1'b0;
    i_fft_done = 1'b0;
    check1("idle_done_ignored", o_done, 1'b0);
    host_read(1'b1, 8'd7); check_word("tp5_idle_drop", o_host_rdata, Q);

    // Randomized traffic, checked each cycle by the compare process.
    repeat (800) begin
      i_raddress1 = rand_addr(); i_raddress2 = rand_addr();
      i_waddress1 = rand_addr(); i_waddress2 = rand_addr();
      i_wdata1 = rand_word(); i_wdata2 = rand_word();
      i_global_write_enable = 1'($urandom_range(0, 1));
      i_sram_read_register  = 1'($urandom_range(0, 1));
      i_start      = ($urandom_range(0, 7) == 0);
      i_fft_done   = ($urandom_range(0, 5) == 0);
      i_host_valid = 1'($urandom_range(0, 1));
      i_host_we    = 1'($urandom_range(0, 1));
      i_host_bank  = 1'($urandom_range(0, 1));
      i_host_addr  = rand_addr();
      i_host_wdata = rand_word();
      @(negedge clk);
    end

    // Reach RUN deterministically, then reset between clock edges.
    idle_inputs();
    i_fft_done = 1'b1;
    repeat (2) @(negedge clk);
    i_fft_done = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check1("rst_pre_working", o_working, 1'b1);
    #3;
    rstn = 1'b0;
    model_reset();
    #1;
    check1("rst_mid_working", o_working, 1'b0);
    check1("rst_mid_ready", o_host_ready, 1'b1);
    check1("rst_mid_done", o_done, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    host_write(1'b1, 8'd9, W_A5);
    host_read(1'b1, 8'd9);
    check_word("post_reset_rw", o_host_rdata, W_A5);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
